// File: rtl/axil_pkg.sv
// Shared AXI-Lite definitions: response codes, backing-memory FSM states and
// the address range helper used by the memory model.
package axil_pkg;

    localparam logic [1:0] AXIL_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXIL_RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        MEM_IDLE    = 3'd0,
        MEM_WR_WAIT = 3'd1,
        MEM_WR_RESP = 3'd2,
        MEM_RD_WAIT = 3'd3,
        MEM_RD_RESP = 3'd4
    } axil_mem_state_t;

    // True when every address bit above the word index is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned idx_w);
        return (addr >> (idx_w + 32'd2)) == 32'd0;
    endfunction

endpackage

// File: rtl/sp_ram.sv
// Single-port RAM, synchronous write and synchronous read, no reset.
// The read register only updates on enabled cycles, so it holds its word.
module sp_ram #(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/axil_backing_mem.sv
// AXI-Lite subordinate backing memory: one transaction in flight, alternating
// read/write priority, fixed LATENCY. Define AXIL_MEM_STATS_EN for rd/wr counters.
module axil_backing_mem
    import axil_pkg::*;
#(
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] axil_awaddr_sbd,
    input  logic        axil_awvalid_sbd,
    output logic        axil_awready_sbd,
    input  logic [31:0] axil_wdata_sbd,
    input  logic        axil_wvalid_sbd,
    output logic        axil_wready_sbd,
    output logic [1:0]  axil_bresp_sbd,
    output logic        axil_bvalid_sbd,
    input  logic        axil_bready_sbd,
    input  logic [31:0] axil_araddr_sbd,
    input  logic        axil_arvalid_sbd,
    output logic        axil_arready_sbd,
    output logic [31:0] axil_rdata_sbd,
    output logic [1:0]  axil_rresp_sbd,
    output logic        axil_rvalid_sbd,
    input  logic        axil_rready_sbd
`ifdef AXIL_MEM_STATS_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
`endif
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    axil_mem_state_t  state;
    axil_mem_state_t  state_nxt;
    logic             prio_wr;
    logic [CNT_W-1:0] lat_cnt;
    logic             wr_elig;
    logic             rd_elig;
    logic             grant_wr;
    logic             grant_rd;
    logic [31:0]      req_addr;
    logic [IDX_W-1:0] req_idx;
    logic             req_in_range;
    logic [31:0]      ram_rdata;

    // Grant only from IDLE; on a tie prio_wr picks the winner.
    always_comb begin
        wr_elig  = axil_awvalid_sbd && axil_wvalid_sbd;
        rd_elig  = axil_arvalid_sbd;
        grant_wr = 1'b0;
        grant_rd = 1'b0;
        if (!rst && state == MEM_IDLE) begin
            if (wr_elig && (!rd_elig || prio_wr)) begin
                grant_wr = 1'b1;
            end else if (rd_elig) begin
                grant_rd = 1'b1;
            end
        end
    end

    assign axil_awready_sbd = grant_wr;
    assign axil_wready_sbd  = grant_wr;
    assign axil_arready_sbd = grant_rd;

    assign req_addr     = grant_wr ? axil_awaddr_sbd : axil_araddr_sbd;
    assign req_idx      = req_addr[IDX_W+1:2];
    assign req_in_range = addr_in_range(req_addr, IDX_W);

    sp_ram #(
        .DEPTH (DEPTH),
        .WIDTH (32)
    ) u_ram (
        .clk   (clk),
        .en    (grant_wr || grant_rd),
        .we    (grant_wr && req_in_range),
        .addr  (req_idx),
        .wdata (axil_wdata_sbd),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MEM_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            MEM_IDLE: begin
                if (grant_wr) begin
                    state_nxt = MEM_WR_WAIT;
                end else if (grant_rd) begin
                    state_nxt = MEM_RD_WAIT;
                end
            end
            MEM_WR_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = MEM_WR_RESP;
                end
            end
            MEM_WR_RESP: begin
                if (axil_bready_sbd) begin
                    state_nxt = MEM_IDLE;
                end
            end
            MEM_RD_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = MEM_RD_RESP;
                end
            end
            MEM_RD_RESP: begin
                if (axil_rready_sbd) begin
                    state_nxt = MEM_IDLE;
                end
            end
            default: state_nxt = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prio_wr <= 1'b0;
        end else if (grant_wr || grant_rd) begin
            prio_wr <= !prio_wr;
        end
    end

    // Loaded with LATENCY-1 so the WAIT->RESP edge lands LATENCY edges after the grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_cnt <= '0;
        end else if (grant_wr || grant_rd) begin
            lat_cnt <= CNT_W'(LATENCY - 1);
        end else if ((state == MEM_WR_WAIT || state == MEM_RD_WAIT) && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            axil_bvalid_sbd <= 1'b0;
            axil_rvalid_sbd <= 1'b0;
            axil_bresp_sbd  <= AXIL_RESP_OKAY;
            axil_rresp_sbd  <= AXIL_RESP_OKAY;
            axil_rdata_sbd  <= '0;
        end else begin
            axil_bvalid_sbd <= (state_nxt == MEM_WR_RESP);
            axil_rvalid_sbd <= (state_nxt == MEM_RD_RESP);
            if (grant_wr) begin
                axil_bresp_sbd <= req_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
            end
            if (grant_rd) begin
                axil_rresp_sbd <= req_in_range ? AXIL_RESP_OKAY : AXIL_RESP_SLVERR;
            end
            // RAM output is valid from the first WAIT cycle; capture it on entry to RESP.
            if (state == MEM_RD_WAIT && state_nxt == MEM_RD_RESP) begin
                axil_rdata_sbd <= (axil_rresp_sbd == AXIL_RESP_OKAY) ? ram_rdata : '0;
            end
        end
    end

`ifdef AXIL_MEM_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (grant_rd) begin
                rd_count <= rd_count + 32'd1;
            end
            if (grant_wr) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_axil_backing_mem.sv
// Bench for axil_backing_mem: vector table driven through a response scoreboard,
// plus sequences for arbitration, backpressure, reset and LATENCY=1 timing.
`timescale 1ns/1ps
module tb_axil_backing_mem;
    import axil_pkg::*;

    localparam int unsigned LAT = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] awaddr, wdata, araddr, rdata;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
    logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
    logic        s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]  s_bresp, s_rresp;
`ifdef AXIL_MEM_STATS_EN
    logic [31:0] rd_count, wr_count, s_rd_count, s_wr_count;
`endif

    axil_backing_mem #(.DEPTH(1024), .LATENCY(LAT)) u_dut (
        .clk(clk), .rst(rst),
        .axil_awaddr_sbd(awaddr), .axil_awvalid_sbd(awvalid), .axil_awready_sbd(awready),
        .axil_wdata_sbd(wdata), .axil_wvalid_sbd(wvalid), .axil_wready_sbd(wready),
        .axil_bresp_sbd(bresp), .axil_bvalid_sbd(bvalid), .axil_bready_sbd(bready),
        .axil_araddr_sbd(araddr), .axil_arvalid_sbd(arvalid), .axil_arready_sbd(arready),
        .axil_rdata_sbd(rdata), .axil_rresp_sbd(rresp), .axil_rvalid_sbd(rvalid),
        .axil_rready_sbd(rready)
`ifdef AXIL_MEM_STATS_EN
        , .rd_count(rd_count), .wr_count(wr_count)
`endif
    );

    axil_backing_mem #(.DEPTH(16), .LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst(rst),
        .axil_awaddr_sbd(s_awaddr), .axil_awvalid_sbd(s_awvalid), .axil_awready_sbd(s_awready),
        .axil_wdata_sbd(s_wdata), .axil_wvalid_sbd(s_wvalid), .axil_wready_sbd(s_wready),
        .axil_bresp_sbd(s_bresp), .axil_bvalid_sbd(s_bvalid), .axil_bready_sbd(s_bready),
        .axil_araddr_sbd(s_araddr), .axil_arvalid_sbd(s_arvalid), .axil_arready_sbd(s_arready),
        .axil_rdata_sbd(s_rdata), .axil_rresp_sbd(s_rresp), .axil_rvalid_sbd(s_rvalid),
        .axil_rready_sbd(s_rready)
`ifdef AXIL_MEM_STATS_EN
        , .rd_count(s_rd_count), .wr_count(s_wr_count)
`endif
    );

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        is_wr;
        logic [1:0]  resp;
        logic [31:0] data;
        int          hs;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  exp_resp;
        logic [31:0] exp_data;
    } vec_t;
    vec_t vecs[11];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout expected handshake", name);
    endtask

    // Present one request, wait for its grant, optionally queue the expected response.
    task automatic send(input logic is_wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [1:0] er, input logic [31:0] ed, input bit push,
                        output int waited);
        exp_t e;
        @(negedge clk);
        if (is_wr) begin
            awaddr = addr; wdata = data; awvalid = 1'b1; wvalid = 1'b1;
        end else begin
            araddr = addr; arvalid = 1'b1;
        end
        #1;
        waited = 0;
        while (!(is_wr ? (awready && wready) : arready) && waited < 100) begin
            @(negedge clk); #1;
            waited++;
        end
        if (waited >= 100) begin
            fail_now("grant");
            awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        e.is_wr = is_wr; e.resp = er; e.data = ed; e.hs = cyc;
        if (push) sb.push_back(e);
    endtask

    // Wait for the oldest outstanding response and compare it to the scoreboard.
    task automatic collect(input string tag);
        exp_t e;
        int n = 0;
        if (sb.size() == 0) begin
            fail_now({tag, "_sb_empty"});
            return;
        end
        e = sb.pop_front();
        while (!(e.is_wr ? bvalid : rvalid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            fail_now({tag, "_valid"});
            return;
        end
        check({tag, "_latency"}, 32'(cyc - e.hs), 32'(LAT));
        if (e.is_wr) begin
            check({tag, "_bresp"}, 32'(bresp), 32'(e.resp));
        end else begin
            check({tag, "_rresp"}, 32'(rresp), 32'(e.resp));
            check({tag, "_rdata"}, rdata, e.data);
        end
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 32'(e.is_wr ? bvalid : rvalid), 32'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int w;
        int n;
        int g;
        logic got[4];
        logic exp_order[4];
        bit seen;
        int e1, e2, rv_cyc;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, AXIL_RESP_OKAY,   32'h0};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         AXIL_RESP_OKAY,   32'hDEAD_BEEF};
        vecs[2]  = '{1'b0, 32'h0000_1000, 32'h0,         AXIL_RESP_SLVERR, 32'h0};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, AXIL_RESP_OKAY,   32'h0};
        vecs[4]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, AXIL_RESP_SLVERR, 32'h0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         AXIL_RESP_OKAY,   32'hA5A5_A5A5};
        vecs[6]  = '{1'b1, 32'h0000_0FFC, 32'h1111_2222, AXIL_RESP_OKAY,   32'h0};
        vecs[7]  = '{1'b0, 32'h0000_0FFF, 32'h0,         AXIL_RESP_OKAY,   32'h1111_2222};
        vecs[8]  = '{1'b0, 32'h8000_0010, 32'h0,         AXIL_RESP_SLVERR, 32'h0};
        vecs[9]  = '{1'b1, 32'h0000_0017, 32'h0F0F_0F0F, AXIL_RESP_OKAY,   32'h0};
        vecs[10] = '{1'b0, 32'h0000_0014, 32'h0,         AXIL_RESP_OKAY,   32'h0F0F_0F0F};
        exp_order = '{1'b0, 1'b1, 1'b0, 1'b1};

        rst = 1'b1;
        awaddr = '0; wdata = '0; araddr = '0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        bready = 1'b1; rready = 1'b1;
        s_awaddr = '0; s_wdata = '0; s_araddr = '0;
        s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
        s_bready = 1'b1; s_rready = 1'b1;

        // Reset state, with requests pending that must not be granted.
        repeat (3) @(negedge clk);
        #1;
        check("rst_arready", 32'(arready), 32'd0);
        check("rst_awready", 32'(awready), 32'd0);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_resp", 32'({bresp, rresp}), 32'd0);
`ifdef AXIL_MEM_STATS_EN
        check("rst_rd_count", rd_count, 32'd0);
        check("rst_wr_count", wr_count, 32'd0);
`endif
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            send(vecs[i].is_wr, vecs[i].addr, vecs[i].data, vecs[i].exp_resp, vecs[i].exp_data, 1'b1, w);
            collect($sformatf("vec%0d", i));
        end

        // AW valid alone must wait for W.
        @(negedge clk);
        awaddr = 32'h20; awvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("aw_alone_ready%0d", i), 32'({awready, wready}), 32'd0);
        end
        awvalid = 1'b0;

        // Continuous AW/W/AR from reset: grants alternate R, W, R, W.
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        awaddr = 32'h24; wdata = 32'h99; araddr = 32'h10;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        rst = 1'b0;
        g = 0; n = 0;
        while (g < 4 && n < 200) begin
            #1;
            if (awready != wready) check("arb_aw_w_together", 32'(wready), 32'(awready));
            if (arready || awready) begin
                if (arready && awready) fail_now("arb_double_grant");
                got[g] = awready;
                g++;
            end
            if (g < 4) begin
                @(negedge clk);
                n++;
            end
        end
        if (g < 4) fail_now("arb_grants");
        @(posedge clk); #1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i < g) check($sformatf("arb_grant%0d_is_wr", i), 32'(got[i]), 32'(exp_order[i]));
        end
        repeat (LAT + 4) @(posedge clk);
        #1;
`ifdef AXIL_MEM_STATS_EN
        check("arb_rd_count", rd_count, 32'd2);
        check("arb_wr_count", wr_count, 32'd2);
`endif
        check("arb_idle_bvalid", 32'(bvalid), 32'd0);

        // Backpressure: response held, new requests stalled.
        rready = 1'b0;
        send(1'b0, 32'h10, 32'h0, AXIL_RESP_OKAY, 32'hDEAD_BEEF, 1'b1, w);
        n = 0;
        while (!rvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail_now("bp_rvalid");
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("bp_latency", 32'(cyc - e.hs), 32'(LAT));
            check("bp_rdata_first", rdata, e.data);
        end
        @(negedge clk);
        awaddr = 32'h28; araddr = 32'h0;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk); #1;
            check($sformatf("bp_rvalid%0d", i), 32'(rvalid), 32'd1);
            check($sformatf("bp_rdata%0d", i), rdata, 32'hDEAD_BEEF);
            check($sformatf("bp_readies%0d", i), 32'({awready, arready}), 32'd0);
        end
        rready = 1'b1;
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        @(posedge clk); #1;
        check("bp_rvalid_drop", 32'(rvalid), 32'd0);

        // Reset during RD_WAIT: no response, back in IDLE, storage kept.
        send(1'b0, 32'h10, 32'h0, AXIL_RESP_OKAY, 32'h0, 1'b0, w);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstwait_rvalid", 32'(rvalid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < LAT + 4; i++) begin
            @(negedge clk);
            if (rvalid) seen = 1'b1;
        end
        check("rstwait_no_rvalid", 32'(seen), 32'd0);
        send(1'b0, 32'h10, 32'h0, AXIL_RESP_OKAY, 32'hDEAD_BEEF, 1'b1, w);
        check("rstwait_idle_grant", 32'(w), 32'd0);
        collect("rstwait_read");

        // Reset during RD_RESP: outputs return to reset values at once.
        rready = 1'b0;
        send(1'b0, 32'h0, 32'h0, AXIL_RESP_OKAY, 32'h0, 1'b0, w);
        n = 0;
        while (!rvalid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) fail_now("rstresp_rvalid");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstresp_rvalid", 32'(rvalid), 32'd0);
        check("rstresp_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rready = 1'b1;

        // Reset during WR_WAIT: the handshaken write stays committed.
        send(1'b1, 32'h30, 32'h0BAD_F00D, AXIL_RESP_OKAY, 32'h0, 1'b0, w);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        send(1'b0, 32'h30, 32'h0, AXIL_RESP_OKAY, 32'h0BAD_F00D, 1'b1, w);
        collect("rstwr_read");

        // LATENCY=1 instance: write, then back-to-back reads.
        @(negedge clk);
        s_awaddr = 32'h4; s_wdata = 32'h77; s_awvalid = 1'b1; s_wvalid = 1'b1;
        #1;
        check("l1_awready", 32'(s_awready), 32'd1);
        @(posedge clk); #1;
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        e1 = cyc;
        n = 0;
        while (!s_bvalid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("l1_b_latency", 32'(cyc - e1), 32'd1);
        check("l1_bresp", 32'(s_bresp), 32'(AXIL_RESP_OKAY));

        @(negedge clk);
        s_araddr = 32'h4; s_arvalid = 1'b1;
        e1 = -1; e2 = -1; rv_cyc = -1; n = 0;
        while (e2 < 0 && n < 50) begin
            #1;
            if (s_rvalid && rv_cyc < 0) begin
                rv_cyc = cyc;
                check("l1_rdata", s_rdata, 32'h77);
            end
            if (s_arready) begin
                if (e1 < 0) e1 = cyc + 1;
                else e2 = cyc + 1;
            end
            if (e2 < 0) begin
                @(negedge clk);
                n++;
            end
        end
        @(posedge clk); #1;
        s_arvalid = 1'b0;
        if (e2 < 0 || rv_cyc < 0) fail_now("l1_reads");
        else begin
            check("l1_r_latency", 32'(rv_cyc - e1), 32'd1);
            check("l1_grant_gap", 32'(e2 - e1), 32'd3);
        end
        repeat (4) @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
